// File: rtl/csm_port_master.sv
// csm_port_master
// Requester-side engine for one port of the CSM shared-memory block. Takes one
// read/write command at a time from a local client, runs hold/grant, address
// phase, data phase, ack/err capture and release, and returns one response.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_rw/addr/wdata/keep      command fields (keep = hold lock for next cmd)
//   rsp_valid                   one-cycle response strobe
//   rsp_rdata/err/timeout       response fields, valid with rsp_valid
//   csm_in_AD/rw/enable         multiplexed address/data phase outputs
//   csm_hold/csm_release        lock request and one-cycle unlock pulse
//   csm_out_data/err/ack        CSM read data, error code, grant/phase ack
module csm_port_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int AD_W    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_keep,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              rsp_timeout,
    output logic [AD_W-1:0]   csm_in_AD,
    output logic              csm_rw,
    output logic              csm_enable,
    output logic              csm_hold,
    output logic              csm_release,
    input  logic [DATA_W-1:0] csm_out_data,
    input  logic [1:0]        csm_err,
    input  logic              csm_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, RESP, REL} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              keep_q;

    wire cnt_expire = (cnt == CW'(TIMEOUT - 1));

    // Every output is written alongside the state it belongs to, so the
    // registered outputs always reflect the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            keep_q      <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 2'b00;
            rsp_timeout <= 1'b0;
            csm_in_AD   <= '0;
            csm_rw      <= 1'b0;
            csm_enable  <= 1'b0;
            csm_hold    <= 1'b0;
            csm_release <= 1'b0;
        end else begin
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            csm_release <= 1'b0;
            csm_enable  <= 1'b0;
            csm_rw      <= 1'b0;
            csm_in_AD   <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rw_q        <= cmd_rw;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        keep_q      <= cmd_keep;
                        rsp_rdata   <= '0;
                        rsp_err     <= 2'b00;
                        rsp_timeout <= 1'b0;
                        cnt         <= '0;
                        csm_hold    <= 1'b1;
                        state       <= REQ;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                REQ: begin
                    if (csm_ack) begin
                        csm_hold   <= 1'b1;
                        csm_enable <= 1'b1;
                        csm_rw     <= rw_q;
                        csm_in_AD  <= AD_W'(addr_q);
                        state      <= ADDR;
                    end else if (cnt_expire) begin
                        // Grant never came: report and release without a data phase.
                        cnt         <= CW'(TIMEOUT);
                        rsp_timeout <= 1'b1;
                        rsp_err     <= 2'b11;
                        rsp_valid   <= 1'b1;
                        csm_hold    <= 1'b0;
                        state       <= RESP;
                    end else begin
                        if (cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
                        csm_hold <= 1'b1;
                    end
                end
                ADDR: begin
                    cnt        <= '0;
                    csm_hold   <= 1'b1;
                    csm_enable <= 1'b1;
                    csm_rw     <= rw_q;
                    csm_in_AD  <= rw_q ? '0 : AD_W'(wdata_q);
                    state      <= DATA;
                end
                DATA: begin
                    if (csm_ack) begin
                        rsp_err   <= csm_err;
                        if (rw_q) rsp_rdata <= csm_out_data;
                        rsp_valid <= 1'b1;
                        csm_hold  <= 1'b1;
                        cmd_ready <= keep_q;  // open for a chained command
                        state     <= RESP;
                    end else if (cnt_expire) begin
                        cnt         <= CW'(TIMEOUT);
                        rsp_timeout <= 1'b1;
                        rsp_err     <= 2'b11;
                        rsp_valid   <= 1'b1;
                        csm_hold    <= 1'b0;
                        state       <= RESP;
                    end else begin
                        if (cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
                        csm_hold   <= 1'b1;
                        csm_enable <= 1'b1;
                        csm_rw     <= rw_q;
                        csm_in_AD  <= rw_q ? '0 : AD_W'(wdata_q);
                    end
                end
                RESP: begin
                    // cmd_ready here already encodes keep && !timeout.
                    if (cmd_ready && cmd_valid) begin
                        rw_q        <= cmd_rw;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        keep_q      <= cmd_keep;
                        rsp_rdata   <= '0;
                        rsp_err     <= 2'b00;
                        rsp_timeout <= 1'b0;
                        csm_hold    <= 1'b1;
                        csm_enable  <= 1'b1;
                        csm_rw      <= cmd_rw;
                        csm_in_AD   <= AD_W'(cmd_addr);
                        state       <= ADDR;
                    end else begin
                        csm_hold    <= 1'b0;
                        csm_release <= 1'b1;
                        state       <= REL;
                    end
                end
                REL: begin
                    csm_hold  <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    csm_hold  <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csm_port_master.sv
// tb_csm_port_master
// Drives csm_port_master with directed and randomized command bursts. The
// bench plays the CSM: for each command it picks a grant delay, data delay,
// error code and read data, then walks the protocol phase by phase and checks
// every cycle's outputs against what the phase rules say they must be.
module tb_csm_port_master;
    localparam int ADDR_W = 8, DATA_W = 8, AD_W = 8, TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, cmd_rw, cmd_keep;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;
    logic [AD_W-1:0]   csm_in_AD;
    logic              csm_rw, csm_enable, csm_hold, csm_release;
    logic [DATA_W-1:0] csm_out_data;
    logic [1:0]        csm_err;
    logic              csm_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         keep;
        int         g;      // REQ cycle carrying the grant (>TIMEOUT: none)
        int         d;      // DATA cycle carrying the ack (>TIMEOUT: none)
        logic [1:0] err;
        logic [7:0] rdata;
    } cmd_t;

    csm_port_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AD_W(AD_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_keep(cmd_keep),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .csm_in_AD(csm_in_AD), .csm_rw(csm_rw), .csm_enable(csm_enable),
        .csm_hold(csm_hold), .csm_release(csm_release),
        .csm_out_data(csm_out_data), .csm_err(csm_err), .csm_ack(csm_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] rn2();
        return 2'($urandom);
    endfunction
    function automatic logic [7:0] rn8();
        return 8'($urandom);
    endfunction

    // {cmd_ready, rsp_valid, hold, enable, rw, release, AD}
    function automatic logic [13:0] ctl(bit rdy, bit vld, bit hold, bit en, bit rw, bit rel,
                                        logic [7:0] ad);
        return {rdy, vld, hold, en, rw, rel, ad};
    endfunction

    function automatic cmd_t mk(bit rw, logic [7:0] addr, logic [7:0] wdata, bit keep,
                                int g, int d, logic [1:0] err, logic [7:0] rdata);
        cmd_t c;
        c.rw = rw; c.addr = addr; c.wdata = wdata; c.keep = keep;
        c.g = g; c.d = d; c.err = err; c.rdata = rdata;
        return c;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: check this cycle's outputs, then set the CSM
    // inputs that the next rising edge samples.
    task automatic step(string tag, logic [13:0] exp, bit ack, logic [1:0] e, logic [7:0] od);
        chk(tag, {cmd_ready, rsp_valid, csm_hold, csm_enable, csm_rw, csm_release, csm_in_AD}, exp);
        csm_ack = ack; csm_err = e; csm_out_data = od;
        @(negedge clk);
    endtask

    task automatic drive_cmd(cmd_t c);
        cmd_valid = 1'b1; cmd_rw = c.rw; cmd_addr = c.addr;
        cmd_wdata = c.wdata; cmd_keep = c.keep;
    endtask

    // Runs a burst starting in IDLE; a command chains onto the previous one
    // when that one had keep set, did not time out and a successor exists.
    task automatic run_burst(input cmd_t cs[$]);
        bit chained = 0;
        for (int i = 0; i < cs.size(); i++) begin
            cmd_t c = cs[i];
            bit to = 0;
            bit nxt;
            if (!chained) begin
                drive_cmd(c);
                step("idle", ctl(1,0,0,0,0,0,8'h00), bit'($urandom), rn2(), rn8());
                cmd_valid = 1'b0;
                for (int k = 1; k <= TIMEOUT; k++) begin
                    bit a = (k == c.g);
                    step("req", ctl(0,0,1,0,0,0,8'h00), a, rn2(), rn8());
                    if (a) break;
                    if (k == TIMEOUT) to = 1;
                end
            end
            if (!to) begin
                step("addr", ctl(0,0,1,1,c.rw,0,c.addr), bit'($urandom), rn2(), rn8());
                for (int k = 1; k <= TIMEOUT; k++) begin
                    bit a = (k == c.d);
                    step("data", ctl(0,0,1,1,c.rw,0, c.rw ? 8'h00 : c.wdata), a,
                         a ? c.err : rn2(), a ? c.rdata : rn8());
                    if (a) break;
                    if (k == TIMEOUT) to = 1;
                end
            end
            chk("rsp_timeout", rsp_timeout, to);
            chk("rsp_err", rsp_err, to ? 2'b11 : c.err);
            chk("rsp_rdata", rsp_rdata, (to || !c.rw) ? 8'h00 : c.rdata);
            nxt = c.keep && !to && (i + 1 < cs.size());
            if (nxt) begin
                drive_cmd(cs[i+1]);
            end else if (!c.keep || to) begin
                // A command offered when chaining is not allowed must be ignored.
                drive_cmd(mk(bit'($urandom), rn8(), rn8(), 1'b1, 1, 1, 2'b00, 8'h00));
            end
            step("resp", ctl(c.keep && !to, 1, !to, 0,0,0,8'h00), bit'($urandom), rn2(), rn8());
            cmd_valid = 1'b0;
            if (nxt) begin
                chained = 1;
            end else begin
                step("rel", ctl(0,0,0,0,0,1,8'h00), bit'($urandom), rn2(), rn8());
                chained = 0;
            end
        end
    endtask

    function automatic int rnd_delay();
        return ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, 4));
    endfunction

    initial begin
        cmd_t q[$];
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_keep = 1'b0; csm_ack = 1'b0; csm_err = 2'b00; csm_out_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctl", {cmd_ready, rsp_valid, csm_hold, csm_enable, csm_rw, csm_release, csm_in_AD},
            ctl(1,0,0,0,0,0,8'h00));
        chk("reset_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 11'h000);
        reset = 1'b0;
        @(negedge clk);

        // Basic write, read, grant timeout.
        q = '{mk(0, 8'h12, 8'hA5, 0, 1, 1, 2'b00, 8'h77)};  run_burst(q);
        q = '{mk(1, 8'h34, 8'h99, 0, 1, 2, 2'b00, 8'h5C)};  run_burst(q);
        q = '{mk(1, 8'h56, 8'h00, 0, TIMEOUT + 1, 1, 2'b00, 8'h11)}; run_burst(q);
        // Keep chain: second command skips REQ, one release at the end.
        q = '{mk(0, 8'h01, 8'h3C, 1, 2, 1, 2'b00, 8'h00),
              mk(1, 8'h02, 8'h00, 0, 1, 3, 2'b01, 8'hE7)};
        run_burst(q);
        // Error pass-through, boundary delays, data timeout, keep without successor.
        q = '{mk(0, 8'h40, 8'h81, 0, 1, 1, 2'b10, 8'h00)};  run_burst(q);
        q = '{mk(1, 8'hFF, 8'h00, 0, TIMEOUT, TIMEOUT, 2'b01, 8'hC3)}; run_burst(q);
        q = '{mk(0, 8'h80, 8'h42, 1, 3, TIMEOUT + 1, 2'b00, 8'h00)}; run_burst(q);
        q = '{mk(1, 8'h0F, 8'h00, 1, 1, 1, 2'b11, 8'h3A)};  run_burst(q);
        q = '{mk(0, 8'h10, 8'h20, 1, TIMEOUT + 1, 1, 2'b00, 8'h00)}; run_burst(q);

        // Reset during DATA drops the command cleanly.
        drive_cmd(mk(0, 8'h66, 8'h99, 0, 1, 1, 2'b00, 8'h00));
        step("rst_idle", ctl(1,0,0,0,0,0,8'h00), 1'b0, 2'b00, 8'h00);
        cmd_valid = 1'b0;
        step("rst_req", ctl(0,0,1,0,0,0,8'h00), 1'b1, 2'b00, 8'h00);
        step("rst_addr", ctl(0,0,1,1,0,0,8'h66), 1'b0, 2'b00, 8'h00);
        chk("rst_data", {cmd_ready, rsp_valid, csm_hold, csm_enable, csm_rw, csm_release, csm_in_AD},
            ctl(0,0,1,1,0,0,8'h99));
        reset = 1'b1; csm_ack = 1'b1;
        @(negedge clk);
        chk("rst_after", {cmd_ready, rsp_valid, csm_hold, csm_enable, csm_rw, csm_release, csm_in_AD},
            ctl(1,0,0,0,0,0,8'h00));
        reset = 1'b0; csm_ack = 1'b0;
        q = '{mk(1, 8'h77, 8'h00, 0, 2, 2, 2'b00, 8'hB4)};  run_burst(q);

        // Randomized bursts.
        for (int b = 0; b < 40; b++) begin
            int n = $urandom_range(1, 3);
            q = {};
            for (int j = 0; j < n; j++)
                q.push_back(mk(bit'($urandom), rn8(), rn8(), bit'($urandom),
                               rnd_delay(), rnd_delay(), rn2(), rn8()));
            run_burst(q);
        end

        chk("final_idle", {cmd_ready, rsp_valid, csm_hold, csm_enable, csm_rw, csm_release, csm_in_AD},
            ctl(1,0,0,0,0,0,8'h00));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csm_port_master.md
Name: csm_port_master

Overview:
- Requester-side engine for one port (A or B) of the CSM shared-memory block.
- Accepts single read/write commands from a local client and runs the CSM port protocol: hold/grant, address phase, data phase, ack/err capture, release.
- Returns one response per command.
- Instantiated once per CSM port, so two instances exercise A/B contention.

Parameters:
- ADDR_W, 8, address width; must be <= AD_W.
- DATA_W, 8, data width; must be <= AD_W.
- AD_W, 8, width of the multiplexed address/data bus.
- TIMEOUT, 16, cycles to wait for csm_ack in REQ or DATA before aborting; must be >= 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- cmd_keep  in  1  keep the lock after this command for a back-to-back command.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  2  captured csm_err; 2'b11 on timeout.
- rsp_timeout  out  1  ack never arrived.
- csm_in_AD  out  AD_W  multiplexed address/data to the CSM.
- csm_rw  out  1  1 = read.
- csm_enable  out  1  phase strobe.
- csm_hold  out  1  lock request / ownership.
- csm_release  out  1  one-cycle unlock pulse.
- csm_out_data  in  DATA_W  read data from the CSM.
- csm_err  in  2  error code, valid with csm_ack.
- csm_ack  in  1  grant or phase acknowledge.

Behaviour:
- Reset (synchronous): state IDLE. All outputs 0 after the edge, except cmd_ready = 1. Timeout counter = 0.
- Reset mid-transaction: the in-flight command is dropped. No rsp_valid, no csm_release pulse; csm_hold drops at that edge.
- All outputs are registered and decoded from the state register. csm_ack and csm_err are sampled at the clock edge.
- IDLE:
  - cmd_ready = 1. On accept, latch rw/addr/wdata/keep and go to REQ.
- REQ:
  - csm_hold = 1. Wait for csm_ack; on ack go to ADDR.
  - Timeout counter increments each REQ cycle. Reaching TIMEOUT: rsp_timeout = 1, rsp_err = 2'b11, go to RESP.
- ADDR (exactly 1 cycle):
  - csm_hold = 1, csm_enable = 1, csm_rw = latched rw.
  - csm_in_AD = zero-extended addr.
  - Then go to DATA; counter cleared.
- DATA:
  - csm_hold = 1, csm_enable = 1, csm_rw held.
  - csm_in_AD = zero-extended wdata for a write; 0 for a read.
  - On csm_ack: capture csm_err; on reads also capture csm_out_data into rsp_rdata. Go to RESP.
  - Timeout behaves as in REQ.
- RESP (exactly 1 cycle):
  - rsp_valid = 1. csm_hold stays 1 unless the command timed out.
  - If keep = 1, no timeout occurred, and cmd_valid is high: cmd_ready = 1, latch the new command, go directly to ADDR (REQ skipped).
  - Otherwise go to REL.
- REL (exactly 1 cycle):
  - csm_release = 1, csm_hold = 0. Go to IDLE.
  - A timed-out command also passes through REL, so the CSM is always unlocked.
- csm_ack arriving in IDLE, ADDR, RESP or REL is ignored. csm_err is ignored without csm_ack.
- Best-case latency with csm_ack high on the first REQ cycle and the first DATA cycle: accept at edge 0, rsp_valid on cycle 4, csm_release on cycle 5, cmd_ready again on cycle 6.
- rsp_err passes 2'b01 / 2'b10 through unchanged; the block does not retry.
- The timeout counter width is clog2(TIMEOUT+1). It saturates and never wraps.

Test Plan:
- Write of addr 0x12, data 0xA5; ack one cycle after hold and one cycle after the data phase:
  - ADDR drives csm_in_AD = 0x12, rw = 0; DATA drives 0xA5.
  - rsp_valid with rsp_err = 0, rsp_rdata = 0.
  - One csm_release pulse, then IDLE.
- Read of addr 0x34; DATA ack with csm_out_data = 0x5C, csm_err = 2'b00:
  - rsp_rdata = 0x5C, rsp_err = 0, rsp_timeout = 0.
- Grant withheld (no ack) for TIMEOUT = 16 cycles:
  - rsp_valid with rsp_timeout = 1, rsp_err = 2'b11.
  - csm_release pulses exactly once; csm_enable is never asserted.
- Two commands, the first with cmd_keep = 1, second presented during RESP:
  - csm_hold stays high throughout; the second command skips REQ.
  - A single csm_release pulse after the second response.
- Ack arriving with csm_err = 2'b10 on a write → rsp_err = 2'b10, rsp_timeout = 0, normal release.
- reset asserted during DATA:
  - Next cycle all CSM outputs = 0, no rsp_valid, cmd_ready = 1.
  - The next command completes normally.
